// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared widths and the round-robin pick helper for the shared multiplier
package booth_arb_pkg;
   localparam int OPW      = 16;
   localparam int PW       = 32;
   localparam int NREQ_DEF = 4;
   localparam int MAXREQ   = 8;

   // one-hot of the first set bit of req, searching upward from last+1 and wrapping at n
   function automatic logic [MAXREQ-1:0] rr_onehot(input logic [MAXREQ-1:0] req, input int last, input int n);
      logic [MAXREQ-1:0] g;
      logic [2:0] idx;
      g = '0;
      for (int k = MAXREQ; k >= 1; k--) begin
         idx = 3'((last + k) % n);
         if (k <= n && req[idx]) g = MAXREQ'(1) << idx;
      end
      return g;
   endfunction
endpackage

// File: rtl/booth_share_arb_if.sv
// booth_share_arb_if: requester/result bus of the shared multiplier
interface booth_share_arb_if import booth_arb_pkg::*; #(
   parameter int NREQ = NREQ_DEF
) ();
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*OPW-1:0] req_a;
   logic [NREQ*OPW-1:0] req_b;
   logic [NREQ-1:0]     rsp_valid;
   logic [NREQ-1:0]     rsp_ready;
   logic [PW-1:0]       rsp_p;
   logic                busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_p, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_p, busy
   );
endinterface

// File: rtl/booth_top.sv
// booth_top: sign-magnitude 16x16 multiplier, product is sign bit over a 31-bit magnitude
module booth_top import booth_arb_pkg::*; (
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic [PW-1:0]  p
);
   logic [2*OPW-3:0] mag;
   logic             neg;

   assign mag = (2*OPW-2)'(a[OPW-2:0]) * (2*OPW-2)'(b[OPW-2:0]);
   // a zero magnitude is always reported as +0
   assign neg = (a[OPW-1] ^ b[OPW-1]) && mag != '0;
   assign p   = {neg, 1'b0, mag};
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over req, pointer advances only when en
module rr_arbiter import booth_arb_pkg::*; #(
   parameter int NREQ = NREQ_DEF,
   parameter int TAGW = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [TAGW-1:0] gnt_idx
);
   logic [TAGW-1:0] last_grant;

   // pick the next valid requester after last_grant and encode its index
   always_comb begin
      gnt     = NREQ'(rr_onehot(MAXREQ'(req), int'(last_grant), NREQ));
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) gnt_idx = TAGW'(i);
   end

   // remember the winner of each completed handshake; reset makes requester 0 first
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_grant <= TAGW'(NREQ-1);
      else if (en) last_grant <= gnt_idx;
endmodule

// File: rtl/booth_share_arb.sv
// booth_share_arb: round-robin sharing of one multiplier by NREQ requesters, two-stage pipeline
module booth_share_arb import booth_arb_pkg::*; #(
   parameter int NREQ = NREQ_DEF,
   parameter int TAGW = $clog2(NREQ)
) (
   input logic clk,
   input logic rst_n,
   booth_share_arb_if.slave bus
);
   logic            s1_valid, s2_valid, s1_go, s2_go, fire;
   logic [TAGW-1:0] s1_tag, s2_tag, gnt_idx;
   logic [OPW-1:0]  s1_a, s1_b, a_sel, b_sel;
   logic [PW-1:0]   s2_p, p;
   logic [NREQ-1:0] gnt;

   assign s2_go         = !s2_valid || bus.rsp_ready[s2_tag];
   assign s1_go         = !s1_valid || s2_go;
   assign bus.req_ready = gnt & {NREQ{s1_go && rst_n}};
   assign fire          = |(bus.req_valid & bus.req_ready);
   assign bus.rsp_valid = s2_valid ? NREQ'(1) << s2_tag : '0;
   assign bus.rsp_p     = s2_p;
   assign bus.busy      = s1_valid || s2_valid;

   rr_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.req_valid),
      .en      (fire),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // select the granted requester's operands
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) begin
            a_sel = bus.req_a[OPW*i +: OPW];
            b_sel = bus.req_b[OPW*i +: OPW];
         end
   end

   booth_top u_mul (
      .a (s1_a),
      .b (s1_b),
      .p (p)
   );

   // stage 1: capture the accepted operands, empty when they move on with nothing new behind
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_tag   <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (fire) begin
         s1_valid <= 1'b1;
         s1_tag   <= gnt_idx;
         s1_a     <= a_sel;
         s1_b     <= b_sel;
      end else if (s1_go) s1_valid <= 1'b0;

   // stage 2: register the product; held while its owner is not ready
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_tag   <= '0;
         s2_p     <= '0;
      end else if (s2_go) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_tag <= s1_tag;
            s2_p   <= p;
         end
      end
endmodule

// File: tb/tb_booth_share_arb.sv
// tb_booth_share_arb: random and directed traffic checked by a scoreboard and a round-robin reference
module tb_booth_share_arb;
   localparam int N = 4;

   typedef struct {
      int          tag;
      logic [31:0] p;
      int          c;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lat_chk = 1'b1;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          last_ref = N-1;
   ent_t        sb[$];
   logic        vld[N];
   logic        acc[N];
   logic [15:0] av[N];
   logic [15:0] bv[N];
   logic [3:0]  rrdy;

   booth_share_arb_if #(.NREQ(N)) bus ();

   booth_share_arb #(.NREQ(N), .TAGW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // sign-magnitude product: sign is the xor of operand signs, magnitude the product of magnitudes
   function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b);
      int unsigned ma, mb, m;
      ma = a[14:0];
      mb = b[14:0];
      m = ma * mb;
      return ((a[15] ^ b[15]) && m != 0) ? (32'h8000_0000 | m) : m;
   endfunction

   function automatic int rr_ref(logic [3:0] v, int last);
      int j;
      for (int k = 1; k <= N; k++) begin
         j = (last + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]        = vld[i];
         bus.req_a[16*i +: 16]   = av[i];
         bus.req_b[16*i +: 16]   = bv[i];
      end
      bus.rsp_ready = rrdy;
   endtask

   // requesters hold an offer until accepted, then re-offer with probability pct
   task automatic drive(int pct);
      for (int i = 0; i < N; i++) begin
         if (!vld[i] || acc[i]) begin
            vld[i] = $urandom_range(99) < pct;
            av[i]  = 16'($urandom);
            bv[i]  = 16'($urandom);
         end
         acc[i] = 1'b0;
      end
      apply();
   endtask

   task automatic directed(int idx, logic [15:0] a, logic [15:0] b, logic [3:0] exp_v, logic [31:0] exp_p);
      int n;
      logic got;
      @(posedge clk); #1;
      vld[idx] = 1'b1;
      av[idx]  = a;
      bv[idx]  = b;
      apply();
      n = 0;
      got = 1'b0;
      while (n < 10 && !got) begin
         @(negedge clk);
         if (bus.rsp_valid != 0) got = 1'b1;
         else begin
            n++;
            @(posedge clk); #1;
            drive(0);
         end
      end
      chk("dir_seen", got, 1);
      chk("dir_latency", n, 2);
      chk("dir_rsp_valid", bus.rsp_valid, exp_v);
      chk("dir_rsp_p", bus.rsp_p, exp_p);
      @(posedge clk); #1;
      drive(0);
   endtask

   // monitor: grants against the round-robin reference, responses against the scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         last_ref = N-1;
      end else begin
         chk("ready_onehot0", $onehot0(bus.req_ready), 1);
         chk("ready_without_valid", |(bus.req_ready & ~bus.req_valid), 0);
         if (bus.rsp_valid != 0) begin
            if (sb.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
            else begin
               chk("rsp_valid_tag", bus.rsp_valid, 4'b1 << sb[0].tag);
               chk("rsp_p", bus.rsp_p, sb[0].p);
               if (bus.rsp_ready[sb[0].tag]) begin
                  if (lat_chk) chk("latency", cyc - sb[0].c, 2);
                  void'(sb.pop_front());
               end
            end
         end
         for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               chk("grant", i, rr_ref(bus.req_valid, last_ref));
               last_ref = i;
               sb.push_back('{i, ref_mul(bus.req_a[16*i +: 16], bus.req_b[16*i +: 16]), cyc});
               acc[i] = 1'b1;
            end
      end
   end

   initial begin
      int n;
      logic [31:0] hold;
      rrdy = '1;
      for (int i = 0; i < N; i++) begin
         vld[i] = 1'b1;
         acc[i] = 1'b0;
         av[i]  = 16'h1111;
         bv[i]  = 16'h2222;
      end
      apply();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", bus.req_ready, 0);
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_rsp_p", bus.rsp_p, 0);
      for (int i = 0; i < N; i++) vld[i] = 1'b0;
      apply();
      @(posedge clk); #1;
      rst_n = 1'b1;

      directed(0, 16'h3300, 16'h2300, 4'b0001, 32'h06F9_0000);
      directed(3, 16'hB300, 16'hA300, 4'b1000, 32'h06F9_0000);

      @(posedge clk); #1;
      drive(100);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("contention_order", bus.req_ready, 4'b1 << (k % 4));
         @(posedge clk); #1;
         drive(100);
      end

      lat_chk = 1'b0;
      rrdy = 4'b1011;
      drive(100);
      n = 0;
      @(negedge clk);
      while (n < 20 && bus.rsp_valid != 4'b0100) begin
         @(posedge clk); #1;
         drive(100);
         @(negedge clk);
         n++;
      end
      chk("bp_stall_seen", bus.rsp_valid, 4'b0100);
      hold = bus.rsp_p;
      for (int k = 0; k < 5; k++) begin
         chk("bp_req_ready", bus.req_ready, 0);
         chk("bp_rsp_p_held", bus.rsp_p, hold);
         chk("bp_busy", bus.busy, 1);
         @(posedge clk); #1;
         drive(100);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rrdy = '1;
      drive(100);
      repeat (6) begin
         @(posedge clk); #1;
         drive(100);
      end

      repeat (400) begin
         @(posedge clk); #1;
         rrdy = 4'($urandom);
         drive(60);
      end

      rrdy = '1;
      repeat (10) begin
         @(posedge clk); #1;
         drive(0);
      end
      @(negedge clk);
      chk("drain_empty", sb.size(), 0);
      chk("drain_busy", bus.busy, 0);

      @(posedge clk); #1;
      rrdy = '0;
      drive(100);
      repeat (4) begin
         @(posedge clk); #1;
         drive(100);
      end
      @(negedge clk);
      chk("pre_reset_busy", bus.busy, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_rsp_valid", bus.rsp_valid, 0);
      chk("midreset_busy", bus.busy, 0);
      chk("midreset_req_ready", bus.req_ready, 0);
      for (int i = 0; i < N; i++) begin
         vld[i] = (i == 1 || i == 2);
         acc[i] = 1'b0;
      end
      rrdy = '1;
      apply();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_grant", bus.req_ready, 4'b0010);
      repeat (8) begin
         @(posedge clk); #1;
         drive(0);
      end
      @(negedge clk);
      chk("post_reset_empty", sb.size(), 0);
      chk("post_reset_busy", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/booth_share_arb.md
BOOTH_SHARE_ARB -- requirements
Module: booth_share_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one multiplier (2..8).
REQ-002 Parameter TAGW, default 2: tag width, equal to clog2(NREQ).
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port req_valid  input  NREQ: per-requester operand valid.
REQ-006 Port req_ready  output  NREQ: per-requester accept; at most one bit high per cycle.
REQ-007 Port req_a  input  NREQ*16: operand A per requester; slice i is [16*i+15:16*i]; 16-bit fixed-point format of booth_top.
REQ-008 Port req_b  input  NREQ*16: operand B per requester; same slicing and format.
REQ-009 Port rsp_valid  output  NREQ: one-hot result valid for the owning requester.
REQ-010 Port rsp_ready  input  NREQ: per-requester result accept.
REQ-011 Port rsp_p  output  32: product, shared by all requesters, qualified by rsp_valid.
REQ-012 Port busy  output  1: high while any pipeline stage holds a valid entry.

Function
REQ-013 The block SHALL contain one booth_top instance, fed only from stage-1 registers.
- Its P output is registered unmodified into stage 2.
REQ-014 Stage 1 holds s1_valid, s1_tag, s1_a and s1_b.
- Stage 2 holds s2_valid, s2_tag and s2_p.
REQ-015 Stage 2 advances (s2_go) when !s2_valid or rsp_ready[s2_tag].
- Stage 1 advances (s1_go) when !s1_valid or s2_go.
REQ-016 Grant: round-robin over requesters with req_valid high.
- Search starts at index (last_grant+1) mod NREQ.
- last_grant resets to NREQ-1, so requester 0 has first priority.
REQ-017 req_ready[g] = 1 only for the granted index g, and only while s1_go.
- Handshake completes when req_valid[g] & req_ready[g].
- On completion, stage 1 loads req_a/req_b slice g and tag g, and last_grant <= g.
REQ-018 last_grant SHALL NOT change on cycles without a completed handshake.
REQ-019 req_ready SHALL depend on req_valid and pipeline state only, never on rsp_p.
- Requesters SHALL NOT make req_valid depend on req_ready.
REQ-020 Latency: a handshake at edge N gives rsp_valid[tag] high after edge N+2 when rsp_ready was not blocking.
REQ-021 rsp_valid = s2_valid ? onehot(s2_tag) : 0, and rsp_p = s2_p.
- Both are held stable while rsp_ready[s2_tag] is low.
REQ-022 Throughput: one product per cycle with no backpressure; no bubbles between back-to-back grants.
REQ-023 Backpressure: while stage 2 stalls, stage 1 stalls once occupied and all req_ready are 0.
- No entry is dropped or duplicated.
REQ-024 Simultaneous stage-2 drain and stage-1 move in the same cycle SHALL be lossless.
REQ-025 A requester never holding req_valid high SHALL never receive a grant.
- With NREQ requesters continuously valid, each SHALL be granted once in every NREQ grants.
REQ-026 busy = s1_valid | s2_valid.

Reset
REQ-027 rst_n low SHALL asynchronously clear s1_valid, s2_valid, req_ready, rsp_valid and busy to 0.
- It SHALL clear tags, data registers and rsp_p to 0, and set last_grant to NREQ-1.
REQ-028 Reset mid-operation SHALL discard in-flight products.
- After rst_n rises, the first grant goes to the lowest-index valid requester.

Structure
REQ-029 A shared package booth_arb_pkg holds OPW=16, PW=32 and the default NREQ.
- It also holds the round-robin one-hot helper function.
REQ-030 One sub-module, rr_arbiter (NREQ-wide round-robin grant with a pointer-update enable), is natural.
- The block instantiates it plus booth_top.

Verification
REQ-031 Single op: requester 0 sends A=0x3300, B=0x2300 with rsp_ready all 1.
- Expect rsp_valid=4'b0001 two cycles after the handshake, with rsp_p=0x06F90000.
REQ-032 Full contention: all 4 requesters valid continuously, rsp_ready=1.
- Expect grants 0,1,2,3,0,1,... on consecutive cycles and one response per cycle with matching tags.
REQ-033 Backpressure: requester 2 result pending with rsp_ready[2]=0 for 5 cycles while others stay valid.
- Expect req_ready all 0 once stage 1 is filled, and rsp_p held stable.
- Expect drain in order after release, with no loss.
REQ-034 Sign cases: A=0xB300, B=0xA300 from requester 3.
- Expect rsp_p equal to booth_top's result for the same operands (0x06F90000) on rsp_valid=4'b1000.
REQ-035 Reset mid-flight: assert rst_n low with both stages valid.
- Expect rsp_valid=0 and busy=0 immediately.
- After release, expect the first grant to the lowest valid index.
